// File: rtl/y_rle_pkg.sv
// y_rle_pkg
// Shared definitions for the y_out run-length encoder:
//   - SYM_W      : width of one Moore-machine output symbol
//   - rle_state_e: run state machine encoding (no open run / run open)
//   - max_run()  : longest run a CNT_W-bit length field can hold
//   - rec_w()    : packed record width; records are packed {sym, len}
//                  with the symbol in the MSBs
package y_rle_pkg;

  localparam int SYM_W = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } rle_state_e;

  // Length 0 is never emitted, so the all-ones value is the longest run.
  function automatic int max_run(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  function automatic int rec_w(input int cnt_w);
    return SYM_W + cnt_w;
  endfunction

endpackage

// File: rtl/rle_sync_fifo.sv
// rle_sync_fifo
// Show-ahead synchronous FIFO for packed run records. The head entry is
// presented on pop_data without needing a pop first.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   push       : write push_data this edge (ignored when full unless pop)
//   push_data  : record to enqueue
//   pop        : remove head entry this edge (ignored when empty)
//   pop_data   : current head entry
//   full/empty : occupancy flags
//   level      : number of stored entries, 0..DEPTH
module rle_sync_fifo
  import y_rle_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_en;
  logic             rd_en;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same edge, so a full FIFO can still
  // accept a push when it is also being popped. Pointers wrap naturally
  // because DEPTH is a power of two.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_en && !rd_en) begin
      level_d = level_q + LVL_W'(1);
    end else if (rd_en && !wr_en) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Storage is cleared on reset so the head reads zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/y_run_encoder.sv
// y_run_encoder
// Run-length encodes the Moore machine's per-cycle 2-bit y_out symbol into
// {symbol, length} records, buffers them in a small FIFO and presents them
// on a valid/ready interface. Records that arrive while the FIFO is full
// and not being drained are dropped and flagged by a sticky overflow bit.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   y_in        : symbol sampled every edge
//   flush       : close the open run at this edge
//   rec_valid   : head record available
//   rec_ready   : consumer accepts the head record
//   rec_sym     : head record symbol
//   rec_len     : head record run length, 1..MAX_RUN
//   fifo_level  : records currently buffered
//   overflow    : sticky, at least one record was dropped
module y_run_encoder
  import y_rle_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SYM_W-1:0]              y_in,
  input  logic                          flush,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [SYM_W-1:0]              rec_sym,
  output logic [CNT_W-1:0]              rec_len,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int             REC_W   = rec_w(CNT_W);
  localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(max_run(CNT_W));

  rle_state_e       state_q, state_d;
  logic [SYM_W-1:0] cur_sym_q, cur_sym_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             overflow_q, overflow_d;

  logic             push;
  logic             pop;
  logic [REC_W-1:0] push_data;
  logic [REC_W-1:0] head_data;
  logic             fifo_full;
  logic             fifo_empty;

  assign push_data = {cur_sym_q, run_len_q};

  // Run state machine. In RUN, a flush outranks a symbol change, which
  // outranks a saturated run; every one of them closes the open run as a
  // record and starts a fresh run of length 1 with the current sample.
  always_comb begin
    state_d   = state_q;
    cur_sym_d = cur_sym_q;
    run_len_d = run_len_q;
    push      = 1'b0;
    if (state_q == ST_EMPTY) begin
      state_d   = ST_RUN;
      cur_sym_d = y_in;
      run_len_d = CNT_W'(1);
    end else begin
      if (flush || (y_in != cur_sym_q)) begin
        push      = 1'b1;
        cur_sym_d = y_in;
        run_len_d = CNT_W'(1);
      end else if (run_len_q == MAX_RUN) begin
        push      = 1'b1;
        run_len_d = CNT_W'(1);
      end else begin
        run_len_d = run_len_q + CNT_W'(1);
      end
    end
  end

  // A record is lost only when the FIFO is full and nobody drains it this
  // edge; the run machine keeps advancing regardless.
  assign pop        = rec_valid && rec_ready;
  assign overflow_d = overflow_q | (push & fifo_full & ~pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      cur_sym_q  <= '0;
      run_len_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_sym_q  <= cur_sym_d;
      run_len_q  <= run_len_d;
      overflow_q <= overflow_d;
    end
  end

  rle_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign rec_valid = ~fifo_empty;
  assign rec_sym   = head_data[REC_W-1 -: SYM_W];
  assign rec_len   = head_data[CNT_W-1:0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_y_run_encoder.sv
// tb_y_run_encoder
// Directed bench for y_run_encoder with a 4-bit length field (MAX_RUN=15)
// and a 4-deep FIFO. Expected records are queued as the stimulus that
// closes each run is issued; a monitor pops and compares on every accepted
// handshake. Flag and level values are compared directly after each edge.
module tb_y_run_encoder;

  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic [1:0]       sym;
    logic [CNT_W-1:0] len;
  } rec_t;

  logic             clk;
  logic             rst;
  logic [1:0]       y_in;
  logic             flush;
  logic             rec_valid;
  logic             rec_ready;
  logic [1:0]       rec_sym;
  logic [CNT_W-1:0] rec_len;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;

  rec_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  y_run_encoder #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .y_in       (y_in),
    .flush      (flush),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_sym    (rec_sym),
    .rec_len    (rec_len),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: inputs change 1 time unit after each rising edge, so at the
  // falling edge a visible handshake is exactly the pop the next edge takes.
  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_record got sym=%0d len=%0d required none", rec_sym, rec_len);
      end else begin
        rec_t e;
        e = expQ.pop_front();
        if (rec_sym !== e.sym || rec_len !== e.len) begin
          errors++;
          $display("[TB] FAIL record got sym=%0d len=%0d required sym=%0d len=%0d",
                   rec_sym, rec_len, e.sym, e.len);
        end
      end
    end
  end

  // Drive one sample, then wait until just after the edge that takes it.
  task automatic applyStimulus(input logic [1:0] y, input logic f, input logic r);
    y_in      = y;
    flush     = f;
    rec_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s got %0h required %0h", name, actual, required);
    end
  endtask

  task automatic expectRec(input logic [1:0] s, input logic [CNT_W-1:0] l);
    rec_t e;
    e.sym = s;
    e.len = l;
    expQ.push_back(e);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    expQ.delete();
  endtask

  // Pop everything with y held so no new run closes; bounded by a budget.
  task automatic drainAll(input logic [1:0] y);
    int n;
    n = 0;
    while (fifo_level != 0 && n < 20) begin
      applyStimulus(y, 1'b0, 1'b1);
      n++;
    end
    checkOutput("drain_done", 32'(fifo_level), 32'd0);
    rec_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst       = 1'b1;
    y_in      = 2'd0;
    flush     = 1'b0;
    rec_ready = 1'b0;

    // Reset state
    doReset();
    checkOutput("rst_valid",    32'(rec_valid),  32'd0);
    checkOutput("rst_sym",      32'(rec_sym),    32'd0);
    checkOutput("rst_len",      32'(rec_len),    32'd0);
    checkOutput("rst_level",    32'(fifo_level), 32'd0);
    checkOutput("rst_overflow", 32'(overflow),   32'd0);

    // Test 1: 01 x3 then 10 closes (01,3); valid rises only after edge 4
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 1'b0, 1'b0);
      checkOutput("t1_no_valid", 32'(rec_valid), 32'd0);
    end
    expectRec(2'b01, 4'd3);
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkOutput("t1_valid", 32'(rec_valid), 32'd1);
    checkOutput("t1_sym",   32'(rec_sym),   32'd1);
    checkOutput("t1_len",   32'(rec_len),   32'd3);
    applyStimulus(2'b10, 1'b0, 1'b1);
    checkOutput("t1_popped", 32'(rec_valid), 32'd0);
    rec_ready = 1'b0;

    // Test 2: 11 for 19 samples; run saturates at 15 on sample 16,
    // samples 16..19 form a run of 4 closed by 00
    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("t2_level0", 32'(fifo_level), 32'd0);
    expectRec(2'b11, 4'd15);
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("t2_level1", 32'(fifo_level), 32'd1);
    checkOutput("t2_sat_len", 32'(rec_len), 32'd15);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("t2_level1b", 32'(fifo_level), 32'd1);
    expectRec(2'b11, 4'd4);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("t2_level2", 32'(fifo_level), 32'd2);
    drainAll(2'b00);

    // Test 3: toggle 00/01 for 7 samples with no reader; 5th and 6th
    // boundaries are dropped
    doReset();
    applyStimulus(2'b00, 1'b0, 1'b0);
    expectRec(2'b00, 4'd1); applyStimulus(2'b01, 1'b0, 1'b0);
    expectRec(2'b01, 4'd1); applyStimulus(2'b00, 1'b0, 1'b0);
    expectRec(2'b00, 4'd1); applyStimulus(2'b01, 1'b0, 1'b0);
    expectRec(2'b01, 4'd1); applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("t3_level4", 32'(fifo_level), 32'd4);
    checkOutput("t3_no_ovf_yet", 32'(overflow), 32'd0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("t3_overflow", 32'(overflow), 32'd1);
    checkOutput("t3_level_sat", 32'(fifo_level), 32'd4);
    applyStimulus(2'b00, 1'b0, 1'b0);
    drainAll(2'b00);
    checkOutput("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Test 4: full FIFO popped on the same edge as a boundary
    doReset();
    checkOutput("t4_ovf_cleared", 32'(overflow), 32'd0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    expectRec(2'b00, 4'd1); applyStimulus(2'b01, 1'b0, 1'b0);
    expectRec(2'b01, 4'd1); applyStimulus(2'b00, 1'b0, 1'b0);
    expectRec(2'b00, 4'd1); applyStimulus(2'b01, 1'b0, 1'b0);
    expectRec(2'b01, 4'd1); applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("t4_full", 32'(fifo_level), 32'd4);
    expectRec(2'b00, 4'd1);
    applyStimulus(2'b01, 1'b0, 1'b1);
    checkOutput("t4_level_kept", 32'(fifo_level), 32'd4);
    checkOutput("t4_no_overflow", 32'(overflow), 32'd0);
    drainAll(2'b01);
    checkOutput("t4_no_overflow_end", 32'(overflow), 32'd0);

    // Test 5: flush ignored while EMPTY, then flush closes (00,5)
    doReset();
    applyStimulus(2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("t5_empty_flush", 32'(fifo_level), 32'd0);
    expectRec(2'b00, 4'd5);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("t5_flush_level", 32'(fifo_level), 32'd1);
    checkOutput("t5_flush_len", 32'(rec_len), 32'd5);
    expectRec(2'b00, 4'd1);
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("t5_level2", 32'(fifo_level), 32'd2);
    drainAll(2'b01);

    // Test 6: reset with two records queued and a run open
    doReset();
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkOutput("t6_queued", 32'(fifo_level), 32'd2);
    doReset();
    checkOutput("t6_valid",    32'(rec_valid),  32'd0);
    checkOutput("t6_level",    32'(fifo_level), 32'd0);
    checkOutput("t6_overflow", 32'(overflow),   32'd0);
    checkOutput("t6_sym",      32'(rec_sym),    32'd0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    expectRec(2'b01, 4'd2);
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkOutput("t6_post_level", 32'(fifo_level), 32'd1);
    drainAll(2'b10);

    checkOutput("all_records_seen", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
